vga_rx: RTL and testbench
=========================

# vga_rx

Receive-side VGA timing recovery for the game display path. Consumes the active-low sync strobes and RGB pixel bus produced by the game's VGA output on its pixel clock. Locks onto the frame structure, regenerates pixel coordinates, validates line and frame geometry, and produces a per-frame pixel checksum. Serves as an on-chip loopback checker and as the capture front-end for frame-comparison tests.

## Interface
- COLOR_BITS, 24: total RGB width, split evenly across the three channels.
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: horizontal timing in pixels; H_TOTAL is their sum.
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: vertical timing in lines; V_TOTAL is their sum.
- clk_i  in  1  pixel clock, one pixel per cycle.
- reset_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- hsync_ni, vsync_ni  in  1 each  active-low sync strobes.
- red_i, green_i, blue_i  in  COLOR_BITS/3 each  pixel channels.
- x_o, y_o  out  10 each  visible-area coordinate of pixel_o.
- pixel_o  out  COLOR_BITS  {red, green, blue} of the current pixel.
- pixel_valid_o  out  1  pixel_o, x_o and y_o are a visible pixel; asserted only when locked.
- frame_done_o  out  1  one-cycle pulse on the last visible pixel of a locked frame.
- frame_sum_o  out  16  checksum of the last completed locked frame.
- locked_o  out  1  timing lock established.
- sync_error_o  out  1  one-cycle pulse on any detected timing violation.

## Operation
- All inputs pass through one input register stage. Sync registers and their previous-value registers reset to 1, so reset release never produces a false edge.
- hcnt: the pixel sampled on the first cycle hsync_ni is seen low has hcnt=0. hcnt increments every cycle and saturates at 2*H_TOTAL.
- Line start is an hsync falling edge. At each line start:
  - vcnt increments.
  - If registered vsync is low and was high at the previous line start, this is a frame start and vcnt←0.
- Visible pixel:
  - hcnt in [H_SYNC+H_BACK, +H_VISIBLE) and vcnt in [V_SYNC+V_BACK, +V_VISIBLE).
  - x = hcnt−(H_SYNC+H_BACK).
  - y = vcnt−(V_SYNC+V_BACK).
- Errors (any one produces a single sync_error_o pulse per cycle):
  - line start with previous hcnt ≠ H_TOTAL−1;
  - hsync low width ≠ H_SYNC;
  - frame start with previous vcnt ≠ V_TOTAL−1;
  - timeout, when hcnt reaches 2*H_TOTAL with no line start.
- Lock FSM has three states: IDLE, ACQUIRE and LOCKED.
  - IDLE→ACQUIRE on a frame start.
  - ACQUIRE→LOCKED on the next frame start, if no error occurred since entering ACQUIRE. On an error, stay in ACQUIRE and re-arm at the next frame start.
  - LOCKED→ACQUIRE on any error.
  - Any state→IDLE on timeout.
  - locked_o=1 only in LOCKED.
- The first-ever frame start is never checked for length. The length check applies only once a previous frame start exists.
- Checksum:
  - 16-bit accumulator, cleared at frame start.
  - Each visible pixel adds pixel[15:0], mod 2^16.
  - frame_sum_o loads the final value (including the last pixel) on the frame_done_o cycle and holds until the next one.
  - Updates only in LOCKED.
- Simultaneous events:
  - A line start on the timeout cycle cancels the timeout.
  - A line-length error and a frame error on the same cycle give one pulse.

## Timing
- Latency from input pins to x_o/y_o/pixel_o/pixel_valid_o is 2 clocks. All outputs are registered.
- sync_error_o and FSM transitions are visible 2 clocks after the offending input sample.
- locked_o rises together with the first pixel output of the frame-start line, on the transition into LOCKED.
- Reset values: every output 0, FSM=IDLE, counters 0, accumulator 0.
- Reset mid-frame:
  - Immediate return to reset values.
  - Relock requires two subsequent frame starts.

## Structure
- Shared package vga_pkg holds:
  - the default timing constants;
  - the lock-state enum (IDLE, ACQUIRE, LOCKED);
  - the checksum width.
- One sub-module, vga_rx_lock_fsm: takes frame_start, error and timeout strobes and produces the state and locked_o.

## Test plan
Benches use H 8/2/2/2 (H_TOTAL=14) and V 4/1/1/1 (V_TOTAL=7), 98 cycles/frame.
- Reset, then clean frames → locked_o=0 through frame 1. locked_o=1 at frame-2 start. First valid output is x=0, y=0, with pixel_o matching the driven 0x112233.
- Locked frame with pixel value = x+8y → frame_done_o pulse at x=7, y=3. frame_sum_o=0x01F0.
- One 15-cycle line inside a locked frame → single sync_error_o pulse, locked_o→0. Relock at the second clean frame start after the error.
- hsync_ni held high for 28+ cycles → timeout error pulse, FSM→IDLE, pixel_valid_o=0.
- 3-cycle hsync pulse while locked → error pulse, locked_o→0.
- reset_ni low mid-frame → outputs 0 asynchronously, with no error pulse on release. locked_o stays 0 until the second frame start after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, lock-state encoding and checksum width shared by the vga_rx slice
package vga_pkg;
  localparam int COLOR_BITS = 24;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int SUM_BITS = 16;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} lock_state_e;
endpackage

// File: rtl/vga_rx_if.sv
// vga_rx_if: video input pins plus recovered pixel/status outputs of the VGA receiver
interface vga_rx_if import vga_pkg::*; #(parameter int COLOR_BITS = vga_pkg::COLOR_BITS);
  logic hsync_ni, vsync_ni;
  logic [COLOR_BITS/3-1:0] red_i, green_i, blue_i;
  logic [9:0] x_o, y_o;
  logic [COLOR_BITS-1:0] pixel_o;
  logic pixel_valid_o, frame_done_o, locked_o, sync_error_o;
  logic [SUM_BITS-1:0] frame_sum_o;
  modport master (
    output hsync_ni, vsync_ni, red_i, green_i, blue_i,
    input x_o, y_o, pixel_o, pixel_valid_o, frame_done_o, frame_sum_o, locked_o, sync_error_o
  );
  modport slave (
    input hsync_ni, vsync_ni, red_i, green_i, blue_i,
    output x_o, y_o, pixel_o, pixel_valid_o, frame_done_o, frame_sum_o, locked_o, sync_error_o
  );
endinterface

// File: rtl/vga_rx_lock_fsm.sv
// vga_rx_lock_fsm: IDLE/ACQUIRE/LOCKED tracking driven by frame-start, error and timeout strobes
module vga_rx_lock_fsm import vga_pkg::*; (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        frame_start,
  input  logic        error,
  input  logic        timeout,
  output lock_state_e next_state,
  output logic        locked_o
);
  lock_state_e state;
  logic err_q, err_nxt;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      err_q <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= err_nxt;
      locked_o <= next_state == LOCKED;
    end
  end
  // err_q marks the current acquisition as dirty; the next frame start re-arms instead of locking
  always_comb begin
    next_state = state;
    if (timeout) next_state = IDLE;
    else if (state == IDLE) next_state = frame_start ? ACQUIRE : IDLE;
    else if (state == ACQUIRE) next_state = frame_start && !err_q && !error ? LOCKED : ACQUIRE;
    else next_state = error ? ACQUIRE : LOCKED;
    err_nxt = next_state == ACQUIRE && !frame_start && (err_q || error || state == LOCKED);
  end
endmodule

// File: rtl/vga_rx.sv
// vga_rx: recovers VGA frame timing, pixel coordinates and a per-frame checksum from sync strobes
module vga_rx import vga_pkg::*; #(
  parameter int COLOR_BITS = vga_pkg::COLOR_BITS,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK
) (
  input logic     clk_i,
  input logic     reset_ni,
  vga_rx_if.slave vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(2 * H_TOTAL + 1);
  localparam logic [HW-1:0] H_MAX = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SW = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] X0 = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] X1 = HW'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y0 = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] Y1 = 10'(V_SYNC + V_BACK + V_VISIBLE);
  logic hs_r, hs_p, vs_r, vs_ls, h_seen, v_seen;
  logic [COLOR_BITS-1:0] rgb_r;
  logic [HW-1:0] hcnt_q, hcnt;
  logic [9:0] vcnt_q, vcnt;
  logic line_start, hs_rise, frame_start, timeout, error, vis, valid_nxt, done_nxt;
  logic [SUM_BITS-1:0] acc, acc_nxt;
  lock_state_e next_state;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hs_r <= 1'b1;
      hs_p <= 1'b1;
      vs_r <= 1'b1;
      vs_ls <= 1'b1;
      rgb_r <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
    end else begin
      hs_r <= vga.hsync_ni;
      hs_p <= hs_r;
      vs_r <= vga.vsync_ni;
      rgb_r <= {vga.red_i, vga.green_i, vga.blue_i};
      vs_ls <= line_start ? vs_r : vs_ls;
      hcnt_q <= hcnt;
      vcnt_q <= vcnt;
      h_seen <= h_seen | line_start;
      v_seen <= v_seen | frame_start;
    end
  end
  // hcnt/vcnt describe the pixel currently in the input register, not the previous one
  assign line_start = hs_p && !hs_r;
  assign hs_rise = !hs_p && hs_r;
  assign frame_start = line_start && !vs_r && vs_ls;
  assign hcnt = line_start ? '0 : hcnt_q == H_MAX ? hcnt_q : hcnt_q + 1'b1;
  assign vcnt = !line_start ? vcnt_q : frame_start ? '0 : vcnt_q == '1 ? vcnt_q : vcnt_q + 1'b1;
  assign timeout = hcnt == H_MAX && hcnt_q != H_MAX;
  assign error = timeout
               || (line_start && h_seen && hcnt_q != H_END)
               || (hs_rise && h_seen && hcnt_q != H_SW)
               || (frame_start && v_seen && vcnt_q != V_END);
  assign vis = hcnt >= X0 && hcnt < X1 && vcnt >= Y0 && vcnt < Y1;
  assign valid_nxt = vis && next_state == LOCKED;
  assign done_nxt = valid_nxt && hcnt == X1 - 1'b1 && vcnt == Y1 - 1'b1;
  assign acc_nxt = frame_start ? '0 : acc + (valid_nxt ? rgb_r[SUM_BITS-1:0] : '0);
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc <= '0;
      vga.x_o <= '0;
      vga.y_o <= '0;
      vga.pixel_o <= '0;
      vga.pixel_valid_o <= 1'b0;
      vga.frame_done_o <= 1'b0;
      vga.frame_sum_o <= '0;
      vga.sync_error_o <= 1'b0;
    end else begin
      acc <= acc_nxt;
      vga.x_o <= vis ? 10'(hcnt - X0) : vga.x_o;
      vga.y_o <= vis ? vcnt - Y0 : vga.y_o;
      vga.pixel_o <= vis ? rgb_r : vga.pixel_o;
      vga.pixel_valid_o <= valid_nxt;
      vga.frame_done_o <= done_nxt;
      vga.frame_sum_o <= done_nxt ? acc_nxt : vga.frame_sum_o;
      vga.sync_error_o <= error;
    end
  end
  vga_rx_lock_fsm u_fsm (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .frame_start(frame_start),
    .error(error),
    .timeout(timeout),
    .next_state(next_state),
    .locked_o(vga.locked_o)
  );
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed frame scenarios with random pixels, checked against a frame-level lock/checksum model
module tb_vga_rx;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b1;
  always #5 clk_i = ~clk_i;
  vga_rx_if #(.COLOR_BITS(24)) vga ();
  vga_rx #(
    .COLOR_BITS(24), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .vga(vga)
  );
  typedef struct {
    logic v, d, l, e;
    logic [9:0] x, y;
    logic [23:0] p;
    logic [15:0] s;
  } exp_t;
  exp_t pipe[$];
  int tests = 0;
  int fails = 0;
  int starts = 0;
  int since_ls = 0;
  logic prev_hs = 1'b1;
  logic [15:0] acc_m = '0;
  logic [15:0] sum_m = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic check_out(input exp_t ex);
    chk("pixel_valid", 32'(vga.pixel_valid_o), 32'(ex.v));
    chk("locked", 32'(vga.locked_o), 32'(ex.l));
    chk("sync_error", 32'(vga.sync_error_o), 32'(ex.e));
    chk("frame_done", 32'(vga.frame_done_o), 32'(ex.d));
    chk("frame_sum", 32'(vga.frame_sum_o), 32'(ex.s));
    if (ex.v) begin
      chk("x", 32'(vga.x_o), 32'(ex.x));
      chk("y", 32'(vga.y_o), 32'(ex.y));
      chk("pixel", 32'(vga.pixel_o), 32'(ex.p));
    end
  endtask
  // one pin sample; lock expectation: locked once two frame starts pass with no error or timeout
  task automatic step(input logic hs, input logic vs, input logic [23:0] rgb,
                      input int hc, input int vc, input logic fs, input logic e);
    exp_t ex;
    logic to;
    @(negedge clk_i);
    if (pipe.size() == 2) check_out(pipe.pop_front());
    since_ls = (prev_hs && !hs) ? 0 : since_ls + 1;
    prev_hs = hs;
    to = since_ls == 28;
    if (e || to) starts = 0;
    if (fs) begin
      starts++;
      acc_m = '0;
    end
    ex.l = starts >= 2;
    ex.v = ex.l && hc >= 4 && hc < 12 && vc >= 2 && vc < 6;
    ex.d = ex.v && hc == 11 && vc == 5;
    ex.x = 10'(hc - 4);
    ex.y = 10'(vc - 2);
    ex.p = rgb;
    if (ex.v) acc_m += rgb[15:0];
    if (ex.d) sum_m = acc_m;
    ex.s = sum_m;
    ex.e = e || to;
    pipe.push_back(ex);
    vga.hsync_ni = hs;
    vga.vsync_ni = vs;
    {vga.red_i, vga.green_i, vga.blue_i} = rgb;
  endtask
  task automatic line(input int vc, input int len, input int hw, input int pm,
                      input logic e0, input logic ew);
    for (int h = 0; h < len; h++) begin
      logic [23:0] rgb;
      rgb = pm == 0 ? 24'($urandom) : pm == 1 ? 24'((h - 4) + 8 * (vc - 2)) : 24'h112233;
      step(h >= hw, vc != 0, rgb, h, vc, h == 0 && vc == 0, (h == 0 && e0) || (ew && h == hw));
    end
  endtask
  task automatic frame(input int pm, input int ll, input int sl, input logic e0);
    for (int v = 0; v < 7; v++)
      line(v, v == ll ? 15 : 14, v == sl ? 3 : 2, pm, (v == 0 && e0) || (ll >= 0 && v == ll + 1), v == sl);
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b1, 1'b1, 24'h0, 99, 6, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    #2 reset_ni = 1'b0;
    vga.hsync_ni = 1'b1;
    vga.vsync_ni = 1'b1;
    #1;
    chk("rst_valid", 32'(vga.pixel_valid_o), 32'h0);
    chk("rst_locked", 32'(vga.locked_o), 32'h0);
    chk("rst_error", 32'(vga.sync_error_o), 32'h0);
    chk("rst_done", 32'(vga.frame_done_o), 32'h0);
    chk("rst_sum", 32'(vga.frame_sum_o), 32'h0);
    chk("rst_x", 32'(vga.x_o), 32'h0);
    chk("rst_y", 32'(vga.y_o), 32'h0);
    chk("rst_pixel", 32'(vga.pixel_o), 32'h0);
    pipe.delete();
    starts = 0;
    since_ls = 0;
    prev_hs = 1'b1;
    acc_m = '0;
    sum_m = '0;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask
  initial begin
    vga.hsync_ni = 1'b1;
    vga.vsync_ni = 1'b1;
    {vga.red_i, vga.green_i, vga.blue_i} = '0;
    do_reset();
    frame(2, -1, -1, 1'b0);
    frame(2, -1, -1, 1'b0);
    frame(1, -1, -1, 1'b0);
    chk("ramp_sum", 32'(vga.frame_sum_o), 32'h01F0);
    repeat ($urandom_range(1, 3)) frame(0, -1, -1, 1'b0);
    frame(0, $urandom_range(0, 5), -1, 1'b0);
    repeat (3) frame(0, -1, -1, 1'b0);
    frame(0, -1, $urandom_range(1, 5), 1'b0);
    repeat (3) frame(0, -1, -1, 1'b0);
    idle(30);
    frame(0, -1, -1, 1'b1);
    repeat (2) frame(0, -1, -1, 1'b0);
    for (int v = 0; v < 3; v++) line(v, 14, 2, 0, 1'b0, 1'b0);
    do_reset();
    repeat (3) frame(0, -1, -1, 1'b0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
